// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-master block-RAM port arbiter.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, READ, WRITE, ACK} t_arb_state;

  typedef logic t_req_id;

  localparam int MAX_WAIT = 7;
  localparam int CNT_BITS = $clog2(MAX_WAIT + 1);

  typedef logic [CNT_BITS-1:0] t_wait_cnt;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between the two requesters.
module arb_pick
  import ram_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic    valid_0,
  input  logic    valid_1,
  input  t_req_id last_grant,
  output t_req_id grant_id,
  output logic    any_valid
);

  always_comb begin
    any_valid = valid_0 | valid_1;
    grant_id  = 1'b0;
    if (valid_0 && valid_1) begin
      // Round-robin hands a tie to whoever did not win last time.
      grant_id = FIXED_PRIO ? 1'b0 : ~last_grant;
    end else if (valid_1) begin
      grant_id = 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one synchronous block-RAM port between two valid/ready masters,
// inserting read wait states and stretched write strobes.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_BITS    = 16,
  parameter int WORD_BITS    = 16,
  parameter int READ_CYCLES  = 1,
  parameter int WRITE_CYCLES = 2,
  parameter bit FIXED_PRIO   = 1'b0
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_valid_0,
  input  logic                 in_write_0,
  input  logic [ADDR_BITS-1:0] in_addr_0,
  input  logic [WORD_BITS-1:0] in_data_0,
  output logic                 out_ready_0,
  output logic [WORD_BITS-1:0] out_data_0,
  input  logic                 in_valid_1,
  input  logic                 in_write_1,
  input  logic [ADDR_BITS-1:0] in_addr_1,
  input  logic [WORD_BITS-1:0] in_data_1,
  output logic                 out_ready_1,
  output logic [WORD_BITS-1:0] out_data_1,
  output logic [ADDR_BITS-1:0] out_ram_addr,
  output logic [WORD_BITS-1:0] out_ram_data,
  output logic                 out_ram_write,
  input  logic [WORD_BITS-1:0] in_ram_data,
  output logic [1:0]           out_grant,
  output logic                 out_busy
);

  localparam t_wait_cnt RD_LAST = t_wait_cnt'(READ_CYCLES);
  localparam t_wait_cnt WR_LAST = t_wait_cnt'(WRITE_CYCLES);

  t_arb_state           state_q, state_d;
  t_wait_cnt            cnt_q, cnt_d;
  t_req_id              id_q, id_d;
  t_req_id              last_q, last_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [WORD_BITS-1:0] data_q, data_d;
  logic [WORD_BITS-1:0] rdata_0_q, rdata_0_d;
  logic [WORD_BITS-1:0] rdata_1_q, rdata_1_d;
  logic                 ready_0_q, ready_0_d;
  logic                 ready_1_q, ready_1_d;
  logic                 write_q, write_d;
  logic [1:0]           grant_q, grant_d;
  logic                 busy_q, busy_d;

  t_req_id pick_id;
  logic    any_valid;

  arb_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .valid_0    (in_valid_0),
    .valid_1    (in_valid_1),
    .last_grant (last_q),
    .grant_id   (pick_id),
    .any_valid  (any_valid)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    last_d    = last_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rdata_0_d = rdata_0_q;
    rdata_1_d = rdata_1_q;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          id_d    = pick_id;
          last_d  = pick_id;
          addr_d  = pick_id ? in_addr_1 : in_addr_0;
          data_d  = pick_id ? in_data_1 : in_data_0;
          cnt_d   = '0;
          state_d = (pick_id ? in_write_1 : in_write_0) ? WRITE : READ;
        end
      end
      READ: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == RD_LAST) begin
          if (id_q) rdata_1_d = in_ram_data;
          else      rdata_0_d = in_ram_data;
          state_d = ACK;
        end
      end
      WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == WR_LAST) state_d = ACK;
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with it once registered.
    ready_0_d = (state_d == ACK) && !id_d;
    ready_1_d = (state_d == ACK) &&  id_d;
    write_d   = (state_d == WRITE);
    busy_d    = (state_d != IDLE);
    grant_d   = busy_d ? (id_d ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      addr_q    <= '0;
      data_q    <= '0;
      rdata_0_q <= '0;
      rdata_1_q <= '0;
      ready_0_q <= 1'b0;
      ready_1_q <= 1'b0;
      write_q   <= 1'b0;
      grant_q   <= 2'b00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rdata_0_q <= rdata_0_d;
      rdata_1_q <= rdata_1_d;
      ready_0_q <= ready_0_d;
      ready_1_q <= ready_1_d;
      write_q   <= write_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
    end
  end

  assign out_ready_0   = ready_0_q;
  assign out_ready_1   = ready_1_q;
  assign out_data_0    = rdata_0_q;
  assign out_data_1    = rdata_1_q;
  assign out_ram_addr  = addr_q;
  assign out_ram_data  = data_q;
  assign out_ram_write = write_q;
  assign out_grant     = grant_q;
  assign out_busy      = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Two arbiters (round-robin and fixed priority) on identical request streams,
// each with its own RAM, checked every cycle against a transaction-level model.
module tb_ram_arbiter;

  localparam int RC = 1;
  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ram_load = 1'b0;
  logic        v0 = 1'b0, w0 = 1'b0, v1 = 1'b0, w1 = 1'b0;
  logic [15:0] a0 = '0, d0 = '0, a1 = '0, d1 = '0;

  logic        rdy0 [2];
  logic        rdy1 [2];
  logic        rwr  [2];
  logic        bsy  [2];
  logic [1:0]  gnt  [2];
  logic [15:0] od0  [2];
  logic [15:0] od1  [2];
  logic [15:0] raddr[2];
  logic [15:0] wdat [2];
  logic [15:0] rq   [2];
  logic [15:0] mem  [2][1024];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ram_arbiter #(
      .ADDR_BITS(16), .WORD_BITS(16), .READ_CYCLES(RC), .WRITE_CYCLES(WC),
      .FIXED_PRIO(1'(g))
    ) u_dut (
      .in_clk(clk), .in_rst(rst_n),
      .in_valid_0(v0), .in_write_0(w0), .in_addr_0(a0), .in_data_0(d0),
      .out_ready_0(rdy0[g]), .out_data_0(od0[g]),
      .in_valid_1(v1), .in_write_1(w1), .in_addr_1(a1), .in_data_1(d1),
      .out_ready_1(rdy1[g]), .out_data_1(od1[g]),
      .out_ram_addr(raddr[g]), .out_ram_data(wdat[g]), .out_ram_write(rwr[g]),
      .in_ram_data(rq[g]), .out_grant(gnt[g]), .out_busy(bsy[g])
    );
  end

  function automatic logic [15:0] initv(input int a);
    return (a == 5) ? 16'hBEEF : 16'(a * 37 ^ 16'h5A5A);
  endfunction

  // Synchronous RAMs, one cycle read latency.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ram_load) begin
        for (int a = 0; a < 1024; a++) mem[k][a] <= initv(a);
      end else if (rwr[k]) begin
        mem[k][raddr[k][9:0]] <= wdat[k];
      end
      rq[k] <= mem[k][raddr[k][9:0]];
    end
  end

  // Transaction-level model: a grant at edge t0 occupies the port for
  // RC+2 (read) or WC+2 (write) edges; ready shows in the last of those cycles.
  logic [15:0] sh [2][1024];
  int          cyc;
  bit          m_busy [2];
  int          m_t0   [2];
  int          m_dur  [2];
  bit          m_id   [2];
  bit          m_wr   [2];
  bit          m_last [2];
  logic [15:0] m_addr [2];
  logic [15:0] m_data [2];
  logic [15:0] m_od0  [2];
  logic [15:0] m_od1  [2];

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_t0[k] = 0; m_dur[k] = 0; m_id[k] = 0; m_wr[k] = 0;
      m_last[k] = 1; m_addr[k] = '0; m_data[k] = '0; m_od0[k] = '0; m_od1[k] = '0;
    end
  endtask

  initial begin
    cyc = 0;
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 1024; a++) sh[k][a] = initv(a);
    mreset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) mreset();
      else begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
          if (m_busy[k]) begin
            if (!m_wr[k] && cyc == m_t0[k] + RC + 1) begin
              if (m_id[k]) m_od1[k] = sh[k][m_addr[k][9:0]];
              else         m_od0[k] = sh[k][m_addr[k][9:0]];
            end
            if (cyc == m_t0[k] + m_dur[k]) m_busy[k] = 0;
          end else if (v0 || v1) begin
            bit id;
            id = (v0 && v1) ? ((k == 1) ? 1'b0 : !m_last[k]) : v1;
            m_id[k]   = id;
            m_last[k] = id;
            m_wr[k]   = id ? w1 : w0;
            m_addr[k] = id ? a1 : a0;
            m_data[k] = id ? d1 : d0;
            m_t0[k]   = cyc;
            m_dur[k]  = m_wr[k] ? WC + 2 : RC + 2;
            m_busy[k] = 1;
            if (m_wr[k]) sh[k][m_addr[k][9:0]] = m_data[k];
          end
        end
      end
    end
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        bit live, erdy;
        live = m_busy[k];
        erdy = live && (cyc == m_t0[k] + m_dur[k] - 1);
        chk($sformatf("u%0d grant", k), 32'(gnt[k]),
            live ? (m_id[k] ? 32'd2 : 32'd1) : 32'd0);
        chk($sformatf("u%0d onehot", k), 32'($onehot0(gnt[k])), 32'd1);
        chk($sformatf("u%0d busy", k), 32'(bsy[k]), 32'(live));
        chk($sformatf("u%0d ready0", k), 32'(rdy0[k]), 32'(erdy && !m_id[k]));
        chk($sformatf("u%0d ready1", k), 32'(rdy1[k]), 32'(erdy && m_id[k]));
        chk($sformatf("u%0d ram_write", k), 32'(rwr[k]),
            32'(live && m_wr[k] && cyc <= m_t0[k] + WC));
        chk($sformatf("u%0d ram_addr", k), 32'(raddr[k]), 32'(m_addr[k]));
        chk($sformatf("u%0d ram_data", k), 32'(wdat[k]), 32'(m_data[k]));
        chk($sformatf("u%0d out_data_0", k), 32'(od0[k]), 32'(m_od0[k]));
        chk($sformatf("u%0d out_data_1", k), 32'(od1[k]), 32'(m_od1[k]));
      end
    end
  endtask

  // Observe the round-robin instance for ncyc cycles after a request is posted.
  task automatic watch(input int who, input int ncyc, input int drop_at,
                       input logic [15:0] ea, input logic [15:0] ed,
                       output int first, output int nrdy, output int nwr, output int badbus);
    first = 0; nrdy = 0; nwr = 0; badbus = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (k == drop_at) begin
        if (who == 0) v0 = 1'b0; else v1 = 1'b0;
      end
      if (who == 0 ? rdy0[0] : rdy1[0]) begin
        if (first == 0) first = k;
        nrdy++;
        if (who == 0) v0 = 1'b0; else v1 = 1'b0;
      end
      if (rwr[0]) begin
        nwr++;
        if (raddr[0] !== ea || wdat[0] !== ed) badbus++;
      end
    end
  endtask

  initial begin
    int first, nrdy, nwr, badbus;
    int ng [2];
    logic [1:0] gs [2][4];
    logic [1:0] after1;
    bit pb [2];

    fork compare_loop(); join_none

    #1 rst_n = 1'b0;
    ram_load = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset grant", 32'(gnt[k]), 32'd0);
      chk("reset busy", 32'(bsy[k]), 32'd0);
      chk("reset ready", 32'({rdy0[k], rdy1[k]}), 32'd0);
      chk("reset ram", 32'({rwr[k], raddr[k], wdat[k]}), 32'd0);
      chk("reset out_data", 32'({od0[k], od1[k]}), 32'd0);
    end
    ram_load = 1'b0;
    #1 rst_n = 1'b1;

    // Single read of 0x005 by requester 0.
    @(negedge clk);
    v0 = 1'b1; w0 = 1'b0; a0 = 16'h0005;
    watch(0, 6, 0, 16'h0, 16'h0, first, nrdy, nwr, badbus);
    chk("read latency", 32'(first), 32'd3);
    chk("read ready width", 32'(nrdy), 32'd1);
    chk("read no write strobe", 32'(nwr), 32'd0);
    chk("read data BEEF", 32'(od0[0]), 32'hBEEF);

    // Single write 0x1234 -> 0x3FF by requester 1, then read it back.
    v1 = 1'b1; w1 = 1'b1; a1 = 16'h03FF; d1 = 16'h1234;
    watch(1, 7, 0, 16'h03FF, 16'h1234, first, nrdy, nwr, badbus);
    chk("write strobe cycles", 32'(nwr), 32'd3);
    chk("write bus values", 32'(badbus), 32'd0);
    chk("write latency", 32'(first), 32'd4);
    chk("write ready width", 32'(nrdy), 32'd1);
    chk("write leaves out_data_1", 32'(od1[0]), 32'd0);
    v0 = 1'b1; w0 = 1'b0; a0 = 16'h03FF;
    watch(0, 6, 0, 16'h0, 16'h0, first, nrdy, nwr, badbus);
    chk("readback 3FF", 32'(od0[0]), 32'h1234);

    // Ties: both held continuously after a fresh reset.
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    v0 = 1'b1; w0 = 1'b0; a0 = 16'h0010;
    v1 = 1'b1; w1 = 1'b0; a1 = 16'h0020;
    ng[0] = 0; ng[1] = 0; pb[0] = 0; pb[1] = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (bsy[g] && !pb[g] && ng[g] < 4) begin
          gs[g][ng[g]] = gnt[g];
          ng[g]++;
        end
        pb[g] = bsy[g];
      end
    end
    chk("rr grant count", 32'(ng[0]), 32'd4);
    chk("rr grant order", 32'({gs[0][0], gs[0][1], gs[0][2], gs[0][3]}), 32'b01_10_01_10);
    chk("fixed grant order", 32'({gs[1][0], gs[1][1], gs[1][2], gs[1][3]}), 32'b01_01_01_01);
    chk("fixed req1 starved", 32'(od1[1]), 32'd0);
    chk("fixed req0 data", 32'(od0[1]), 32'(initv(16)));
    chk("rr req1 data", 32'(od1[0]), 32'(initv(32)));
    v0 = 1'b0;
    after1 = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bsy[1] && !pb[1] && after1 == 2'b00) after1 = gnt[1];
      pb[1] = bsy[1];
    end
    chk("fixed req1 after drop", 32'(after1), 32'd2);
    v1 = 1'b0;
    repeat (8) @(negedge clk);

    // Reset pulsed in the second WRITE cycle.
    v0 = 1'b1; w0 = 1'b1; a0 = 16'h0040; d0 = 16'hA5A5;
    @(negedge clk);
    v0 = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("abort write drop", 32'(rwr[k]), 32'd0);
      chk("abort outputs", 32'({gnt[k], bsy[k], rdy0[k], rdy1[k], raddr[k], wdat[k]}), 32'd0);
    end
    #1 rst_n = 1'b1;
    nrdy = 0;
    repeat (4) begin
      @(negedge clk);
      if (rdy0[0] || rdy1[0] || rdy0[1] || rdy1[1]) nrdy++;
    end
    chk("abort no ready", 32'(nrdy), 32'd0);
    v0 = 1'b1; w0 = 1'b0; a0 = 16'h0040;
    v1 = 1'b1; w1 = 1'b0; a1 = 16'h0041;
    @(negedge clk);
    chk("abort tie to req0", 32'(gnt[0]), 32'd1);
    v0 = 1'b0; v1 = 1'b0;
    repeat (6) @(negedge clk);

    // Valid dropped mid-read still completes.
    v1 = 1'b1; w1 = 1'b0; a1 = 16'h0040;
    watch(1, 6, 1, 16'h0, 16'h0, first, nrdy, nwr, badbus);
    chk("dropped valid latency", 32'(first), 32'd3);
    chk("dropped valid ready width", 32'(nrdy), 32'd1);
    chk("dropped valid data", 32'(od1[0]), 32'hA5A5);

    // Random traffic, checked by the model on every cycle.
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      v0 = ($urandom_range(0, 9) < 6);
      v1 = ($urandom_range(0, 9) < 6);
      w0 = $urandom_range(0, 1) == 1;
      w1 = $urandom_range(0, 2) == 0;
      a0 = 16'($urandom_range(0, 15));
      a1 = 16'($urandom_range(0, 15));
      d0 = 16'($urandom);
      d1 = 16'($urandom);
    end
    v0 = 1'b0; v1 = 1'b0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
